// File: rtl/render_frame_sequencer.sv
// rtl/render_frame_sequencer.sv - blanking-window command sequencer and raster scan head for the renderer chain

// Command buffer: holds {stage, reg, data} words until a programming window drains them.
module rfs_cmd_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  // Requests are qualified here so a write into a full buffer or a read of an empty one is a no-op.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module render_frame_sequencer #(
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          BLANK_CYCLES = 64,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [11:0] BG_COLOR     = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_stage,
  input  logic [2:0]  cmd_reg,
  input  logic [11:0] cmd_data,
  output logic        program_out,
  output logic [10:0] x_out,
  output logic [11:0] y_out,
  output logic [11:0] data_out,
  output logic        pix_valid_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PROGRAM,
    SCAN
  } state_t;

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [10:0]   X_LAST     = 11'(H_ACTIVE - 1);
  localparam logic [11:0]   Y_LAST     = 12'(V_ACTIVE - 1);

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] blank_cnt;
  logic [BW-1:0] blank_nxt;
  logic [10:0]   x_cnt;
  logic [10:0]   x_nxt;
  logic [11:0]   y_cnt;
  logic [11:0]   y_nxt;
  logic          frame_done;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [25:0]   fifo_rdata;

  logic          prog_nxt;
  logic [10:0]   xo_nxt;
  logic [11:0]   yo_nxt;
  logic [11:0]   data_nxt;
  logic          pv_nxt;
  logic          fs_nxt;

  // Ready is forced low while reset is held; the FIFO itself is empty then but must not look open.
  assign cmd_ready = !rst && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  rfs_cmd_fifo #(
    .WIDTH (26),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({cmd_stage, cmd_reg, cmd_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer state, blank-window counter and raster position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      blank_cnt <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
    end else begin
      state     <= state_nxt;
      blank_cnt <= blank_nxt;
      x_cnt     <= x_nxt;
      y_cnt     <= y_nxt;
    end
  end

  // Next state plus the beat the current state produces; en only matters in IDLE and at frame end.
  always_comb begin
    state_nxt  = state;
    blank_nxt  = blank_cnt;
    x_nxt      = x_cnt;
    y_nxt      = y_cnt;
    frame_done = 1'b0;
    fifo_pop   = 1'b0;
    prog_nxt   = 1'b0;
    xo_nxt     = '0;
    yo_nxt     = '0;
    data_nxt   = '0;
    pv_nxt     = 1'b0;
    fs_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = PROGRAM;
          blank_nxt = '0;
        end
      end
      PROGRAM: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          prog_nxt = 1'b1;
          xo_nxt   = fifo_rdata[25:15];
          yo_nxt   = {9'b0, fifo_rdata[14:12]};
          data_nxt = fifo_rdata[11:0];
        end
        if (blank_cnt == BLANK_LAST) begin
          state_nxt = SCAN;
          blank_nxt = '0;
          x_nxt     = '0;
          y_nxt     = '0;
        end else begin
          blank_nxt = blank_cnt + 1'b1;
        end
      end
      SCAN: begin
        pv_nxt   = 1'b1;
        xo_nxt   = x_cnt;
        yo_nxt   = y_cnt;
        data_nxt = BG_COLOR;
        fs_nxt   = (x_cnt == '0) && (y_cnt == '0);
        if (x_cnt == X_LAST) begin
          x_nxt = '0;
          if (y_cnt == Y_LAST) begin
            y_nxt      = '0;
            frame_done = 1'b1;
            blank_nxt  = '0;
            state_nxt  = en ? PROGRAM : IDLE;
          end else begin
            y_nxt = y_cnt + 12'd1;
          end
        end else begin
          x_nxt = x_cnt + 11'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered beat outputs and the completed-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      program_out   <= 1'b0;
      x_out         <= '0;
      y_out         <= '0;
      data_out      <= '0;
      pix_valid_out <= 1'b0;
      frame_start   <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      program_out   <= prog_nxt;
      x_out         <= xo_nxt;
      y_out         <= yo_nxt;
      data_out      <= data_nxt;
      pix_valid_out <= pv_nxt;
      frame_start   <= fs_nxt;
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
